// File: rtl/line_clear_engine_pkg.sv
// Shared geometry, state encoding and row-addressing helpers for the line clear engine.
// Boards are MSB-first: row 0 occupies the top COLS bits, row ROWS-1 the bottom COLS bits.
package line_clear_engine_pkg;
  localparam int unsigned ROWS    = 20;
  localparam int unsigned COLS    = 10;
  localparam int unsigned BOARD_W = ROWS * COLS;
  localparam int unsigned POS_W   = $clog2(BOARD_W);
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TOTAL_W = 16;
  localparam int unsigned SUM_W   = TOTAL_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Highest vector bit of row idx; out-of-range indices alias row 0 and are never written.
  function automatic logic [POS_W-1:0] row_msb(input logic [IDX_W-1:0] idx);
    logic [POS_W-1:0] r;
    r = (32'(idx) < ROWS) ? POS_W'(idx) : '0;
    return POS_W'(BOARD_W - 1) - r * POS_W'(COLS);
  endfunction

  // Vector position of the full-line flag for row idx (row 0 is the MSB).
  function automatic logic [IDX_W-1:0] flag_pos(input logic [IDX_W-1:0] idx);
    return (32'(idx) < ROWS) ? IDX_W'(ROWS - 1) - idx : '0;
  endfunction
endpackage

// File: rtl/line_clear_engine_board_row_rw.sv
// Next-value logic for the work board: reads row src and writes it (or zeros) into row dst.
module line_clear_engine_board_row_rw
  import line_clear_engine_pkg::*;
(
  input  logic [BOARD_W-1:0] work_i,
  input  logic [IDX_W-1:0]   src_i,
  input  logic [IDX_W-1:0]   dst_i,
  input  logic               wr_en_i,
  input  logic               wr_zero_i,
  output logic [BOARD_W-1:0] work_c_o
);
  logic [COLS-1:0] rd_row;

  always_comb begin
    rd_row   = work_i[row_msb(src_i) -: COLS];
    work_c_o = work_i;
    // dst only leaves the valid range on the final step, where no write is issued
    if (wr_en_i && (32'(dst_i) < ROWS)) begin
      work_c_o[row_msb(dst_i) -: COLS] = wr_zero_i ? '0 : rd_row;
    end
  end
endmodule

// File: rtl/line_clear_engine.sv
// Removes flagged rows from a board snapshot, compacting survivors downward one row per cycle,
// then reports the new board, the lines cleared and a saturating running total.
module line_clear_engine
  import line_clear_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BOARD_W-1:0] boardIn,
  input  logic [ROWS-1:0]    fullLinesIn,
  output logic               busy,
  output logic               done,
  output logic [BOARD_W-1:0] boardOut,
  output logic [CNT_W-1:0]   linesCleared,
  output logic [TOTAL_W-1:0] linesTotal
);
  state_e               state_q, state_d;
  logic [BOARD_W-1:0]   work_q, work_d, work_rw;
  logic [ROWS-1:0]      mask_q, mask_d;
  logic [IDX_W-1:0]     src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [BOARD_W-1:0]   board_out_q, board_out_d;
  logic [CNT_W-1:0]     lines_cleared_q, lines_cleared_d;
  logic [TOTAL_W-1:0]   lines_total_q, lines_total_d;
  logic                 wr_en, wr_zero, src_flag;
  logic [SUM_W-1:0]     sum;

  line_clear_engine_board_row_rw u_row_rw (
    .work_i    (work_q),
    .src_i     (src_q),
    .dst_i     (dst_q),
    .wr_en_i   (wr_en),
    .wr_zero_i (wr_zero),
    .work_c_o  (work_rw)
  );

  always_comb begin
    state_d         = state_q;
    work_d          = work_rw;
    mask_d          = mask_q;
    src_d           = src_q;
    dst_d           = dst_q;
    count_d         = count_q;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    board_out_d     = board_out_q;
    lines_cleared_d = lines_cleared_q;
    lines_total_d   = lines_total_q;
    wr_en           = 1'b0;
    wr_zero         = 1'b0;
    src_flag        = mask_q[flag_pos(src_q)];
    sum             = SUM_W'(lines_total_q) + SUM_W'(count_q);

    unique case (state_q)
      ST_IDLE: begin
        // done_q is only high in IDLE during the pulse cycle, when start must be ignored
        if (start && !done_q) begin
          work_d  = boardIn;
          mask_d  = fullLinesIn;
          src_d   = IDX_W'(ROWS - 1);
          dst_d   = IDX_W'(ROWS - 1);
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        if (src_flag) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          wr_en = 1'b1;
          dst_d = dst_q - IDX_W'(1);
        end
        src_d = src_q - IDX_W'(1);
        if (src_q == '0) begin
          state_d = (count_d != '0) ? ST_FILL : ST_DONE;
        end
      end
      ST_FILL: begin
        busy_d  = 1'b1;
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        dst_d   = dst_q - IDX_W'(1);
        if (dst_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d          = 1'b1;
        done_d          = 1'b1;
        board_out_d     = work_q;
        lines_cleared_d = count_q;
        lines_total_d   = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      work_q          <= '0;
      mask_q          <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      count_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      board_out_q     <= '0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      mask_q          <= mask_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      board_out_q     <= board_out_d;
      lines_cleared_q <= lines_cleared_d;
      lines_total_q   <= lines_total_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign boardOut     = board_out_q;
  assign linesCleared = lines_cleared_q;
  assign linesTotal   = lines_total_q;
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: hand-built boards, expected boards, latencies and totals.
module tb_line_clear_engine;
  localparam int unsigned ROWS = 20;
  localparam int unsigned COLS = 10;
  localparam int unsigned BW   = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [BW-1:0]   boardIn;
  logic [ROWS-1:0] fullLinesIn;
  logic            busy;
  logic            done;
  logic [BW-1:0]   boardOut;
  logic [4:0]      linesCleared;
  logic [15:0]     linesTotal;

  int checks = 0;
  int errors = 0;

  line_clear_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .boardIn      (boardIn),
    .fullLinesIn  (fullLinesIn),
    .busy         (busy),
    .done         (done),
    .boardOut     (boardOut),
    .linesCleared (linesCleared),
    .linesTotal   (linesTotal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row r occupies the COLS bits starting at the MSB side of the vector.
  function automatic logic [BW-1:0] put_row(input logic [BW-1:0] b, input int r,
                                            input logic [COLS-1:0] v);
    logic [BW-1:0] t;
    t = b;
    t[BW-1-r*COLS -: COLS] = v;
    return t;
  endfunction

  task automatic run_op(input string tag, input logic [BW-1:0] b, input logic [ROWS-1:0] m,
                        input int extra_at, input int exp_lat, input logic [BW-1:0] exp_b,
                        input int exp_n, input int exp_tot);
    int lat;
    lat = -1;
    @(negedge clk);
    boardIn = b; fullLinesIn = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; boardIn = ~b; fullLinesIn = ~m;
    for (int k = 1; k <= 100; k++) begin
      start = (k == extra_at);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".board"}, boardOut, exp_b);
    chk({tag, ".cleared"}, linesCleared, exp_n);
    chk({tag, ".total"}, linesTotal, exp_tot);
    chk({tag, ".busy_at_done"}, busy, 1'b1);
    @(posedge clk); #1;
    chk({tag, ".busy_done_fall"}, {busy, done}, 2'b00);
  endtask

  logic [BW-1:0]   b_rand, b_one, e_one, b_four, e_four;
  logic [ROWS-1:0] m_one, m_four;
  int              j, extra, act;

  initial begin
    rst_n = 1'b0; start = 1'b0; boardIn = '0; fullLinesIn = '0;
    #12;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.board", boardOut, '0);
    chk("reset.cleared", linesCleared, '0);
    chk("reset.total", linesTotal, '0);
    @(negedge clk); rst_n = 1'b1;

    // Empty mask: board passes through unchanged
    for (int i = 0; i < int'(BW); i++) b_rand[i] = 1'($urandom_range(0, 1));
    run_op("empty", b_rand, '0, 0, 21, b_rand, 0, 0);

    // Single bottom line: row 18 drops into row 19
    b_one = '0;
    b_one = put_row(b_one, 19, '1);
    b_one = put_row(b_one, 18, 10'b1010000000);
    e_one = put_row('0, 19, 10'b1010000000);
    m_one = '0;
    m_one[ROWS-1-19] = 1'b1;
    run_op("single", b_one, m_one, 0, 22, e_one, 1, 1);

    // Four non-adjacent lines: survivors keep order in rows 4..19
    b_four = '0; e_four = '0; m_four = '0; j = 4;
    for (int r = 0; r < int'(ROWS); r++) begin
      b_four = put_row(b_four, r, 10'(r + 1));
      if (r == 5 || r == 10 || r == 15 || r == 19) begin
        m_four[ROWS-1-r] = 1'b1;
      end else begin
        e_four = put_row(e_four, j, 10'(r + 1));
        j++;
      end
    end
    run_op("four", b_four, m_four, 0, 25, e_four, 4, 5);

    // All full, with an extra start pulse at E3 that must be ignored
    run_op("full", '1, '1, 3, 41, '0, 20, 25);
    extra = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk("full.single_done", extra, 0);

    // Asynchronous reset in the middle of SCAN
    @(negedge clk);
    boardIn = b_four; fullLinesIn = m_four; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.done", done, 1'b0);
    chk("midrst.board", boardOut, '0);
    chk("midrst.cleared", linesCleared, '0);
    chk("midrst.total", linesTotal, '0);
    @(negedge clk); rst_n = 1'b1;
    act = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) act++;
    end
    chk("midrst.idle_after", act, 0);

    // Saturation of the running total
    @(negedge clk);
    force dut.lines_total_q = 16'd65534;
    @(posedge clk); #1;
    release dut.lines_total_q;
    @(negedge clk);
    chk("sat.preload", linesTotal, 16'd65534);
    run_op("sat4", b_four, m_four, 0, 25, e_four, 4, 65535);
    run_op("sat1", b_one, m_one, 0, 22, e_one, 1, 65535);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
